versatile_fifo_dpram_sc_be: RTL and testbench

VERSATILE_FIFO_DPRAM_SC_BE -- requirements
Module: versatile_fifo_dpram_sc_be

---
 rtl/versatile_fifo_dpram_sc_be_pkg.sv | 14 +
 rtl/versatile_fifo_dpram_sc_be_core.sv | 41 ++++
 rtl/versatile_fifo_dpram_sc_be.sv | 216 +++++++++++++++++++++
 tb/tb_versatile_fifo_dpram_sc_be.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/versatile_fifo_dpram_sc_be_pkg.sv
// Shared definitions for the byte-enable dual-port RAM with clear sweep.
package versatile_fifo_dpram_sc_be_pkg;

    // Clear-sweep controller states
    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } sweep_state_e;

    // Same-port read-during-write behaviour
    localparam int RDW_NEW = 0;
    localparam int RDW_OLD = 1;

endpackage

// File: rtl/versatile_fifo_dpram_sc_be_core.sv
// Byte-lane storage array: two ports, per-byte write, registered read
// returning the pre-write word, no reset on the array or read registers.
module versatile_fifo_dpram_be_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   adr_a,
    input  logic [DATA_WIDTH-1:0]   d_a,
    output logic [DATA_WIDTH-1:0]   q_a,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   adr_b,
    input  logic [DATA_WIDTH-1:0]   d_b,
    output logic [DATA_WIDTH-1:0]   q_b
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Read old contents and write enabled byte lanes; port A is applied last
    always_ff @(posedge clk) begin
        q_a <= mem[adr_a];
        q_b <= mem[adr_b];
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (we_b && be_b[i]) begin
                mem[adr_b][8*i +: 8] <= d_b[8*i +: 8];
            end
        end
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (we_a && be_a[i]) begin
                mem[adr_a][8*i +: 8] <= d_a[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/versatile_fifo_dpram_sc_be.sv
// Single-clock true dual-port RAM with byte enables, a power-up/clr sweep
// that fills every location with INIT_VALUE, selectable same-port
// read-during-write behaviour and an optional output pipeline stage.
module versatile_fifo_dpram_sc_be
    import versatile_fifo_dpram_sc_be_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    init_busy,
    input  logic [DATA_WIDTH-1:0]   d_a,
    input  logic [DATA_WIDTH-1:0]   d_b,
    input  logic [ADDR_WIDTH-1:0]   adr_a,
    input  logic [ADDR_WIDTH-1:0]   adr_b,
    input  logic                    we_a,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    output logic [DATA_WIDTH-1:0]   q_a,
    output logic [DATA_WIDTH-1:0]   q_b
);

    localparam int                    NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX   = '1;

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (RDW_MODE > 1) begin : g_bad_rdw
        $error("RDW_MODE must be 0 or 1");
    end
    if (OUT_REG > 1) begin : g_bad_outreg
        $error("OUT_REG must be 0 or 1");
    end

    // Byte-lane merge: new bytes where be is set, old bytes elsewhere
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    sweep_state_e          state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  init_busy_r;

    logic                  core_we_a_s, core_we_b_s;
    logic [ADDR_WIDTH-1:0] core_adr_a_s;
    logic [DATA_WIDTH-1:0] core_d_a_s;
    logic [NUM_BYTES-1:0]  core_be_a_s, core_be_b_s;
    logic [DATA_WIDTH-1:0] rd_a_s, rd_b_s;

    logic                  zero_r;
    logic                  wr_a_r, wr_b_r;
    logic [DATA_WIDTH-1:0] wd_a_r, wd_b_r;
    logic [NUM_BYTES-1:0]  wbe_a_r, wbe_b_r;
    logic [DATA_WIDTH-1:0] raw_a_s, raw_b_s;

    // Clear-sweep FSM: walks every address once, clr restarts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SWEEP;
            cnt_r       <= '0;
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                SWEEP: begin
                    if (clr) begin
                        cnt_r <= '0;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r     <= READY;
                        cnt_r       <= '0;
                        init_busy_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                READY: begin
                    if (clr) begin
                        state_r     <= SWEEP;
                        cnt_r       <= '0;
                        init_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= SWEEP;
                    cnt_r       <= '0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Write-port steering: sweep owns port A while busy; port A wins shared lanes
    always_comb begin
        core_we_a_s  = 1'b0;
        core_adr_a_s = adr_a;
        core_d_a_s   = d_a;
        core_be_a_s  = be_a;
        core_we_b_s  = 1'b0;
        core_be_b_s  = be_b;
        if (init_busy_r) begin
            core_we_a_s  = 1'b1;
            core_adr_a_s = cnt_r;
            core_d_a_s   = INIT_VALUE;
            core_be_a_s  = '1;
            core_we_b_s  = 1'b0;
        end else begin
            core_we_a_s  = we_a;
            core_we_b_s  = we_b;
            if (we_a && (adr_a == adr_b)) begin
                core_be_b_s = be_b & ~be_a;
            end else begin
                core_be_b_s = be_b;
            end
        end
    end

    versatile_fifo_dpram_be_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we_a  (core_we_a_s),
        .be_a  (core_be_a_s),
        .adr_a (core_adr_a_s),
        .d_a   (core_d_a_s),
        .q_a   (rd_a_s),
        .we_b  (core_we_b_s),
        .be_b  (core_be_b_s),
        .adr_b (adr_b),
        .d_b   (d_b),
        .q_b   (rd_b_s)
    );

    // Track busy and same-port write info alongside the core read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r  <= 1'b1;
            wr_a_r  <= 1'b0;
            wr_b_r  <= 1'b0;
            wd_a_r  <= '0;
            wd_b_r  <= '0;
            wbe_a_r <= '0;
            wbe_b_r <= '0;
        end else begin
            zero_r  <= init_busy_r;
            wr_a_r  <= we_a & ~init_busy_r;
            wr_b_r  <= we_b & ~init_busy_r;
            wd_a_r  <= d_a;
            wd_b_r  <= d_b;
            wbe_a_r <= be_a;
            wbe_b_r <= be_b;
        end
    end

    // Read data shaping: zero while busy, merged new data for same-port writes
    always_comb begin
        raw_a_s = '0;
        raw_b_s = '0;
        if (zero_r) begin
            raw_a_s = '0;
            raw_b_s = '0;
        end else begin
            if ((RDW_MODE == RDW_NEW) && wr_a_r) begin
                raw_a_s = merge_bytes(rd_a_s, wd_a_r, wbe_a_r);
            end else begin
                raw_a_s = rd_a_s;
            end
            if ((RDW_MODE == RDW_NEW) && wr_b_r) begin
                raw_b_s = merge_bytes(rd_b_s, wd_b_r, wbe_b_r);
            end else begin
                raw_b_s = rd_b_s;
            end
        end
    end

    if (OUT_REG == 1) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_a_r, q_b_r;

        // Optional output pipeline stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_a_r <= '0;
                q_b_r <= '0;
            end else begin
                q_a_r <= raw_a_s;
                q_b_r <= raw_b_s;
            end
        end

        assign q_a = q_a_r;
        assign q_b = q_b_r;
    end else begin : g_no_out_reg
        assign q_a = raw_a_s;
        assign q_b = raw_b_s;
    end

    assign init_busy = init_busy_r;

endmodule

// File: tb/tb_versatile_fifo_dpram_sc_be.sv
// Randomised scoreboard bench: two instances (new-data/no out reg and
// old-data/out reg) share stimulus and are compared against a word-level model.
module tb_versatile_fifo_dpram_sc_be;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] INIT  = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n, clr, we_a, we_b;
    logic [3:0]  adr_a, adr_b, be_a, be_b;
    logic [31:0] d_a, d_b;
    logic        busy0, busy1;
    logic [31:0] qa0, qb0, qa1, qb1;

    always #5 clk = ~clk;

    versatile_fifo_dpram_sc_be #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .RDW_MODE (0), .OUT_REG (0), .INIT_VALUE (INIT)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .clr (clr), .init_busy (busy0),
        .d_a (d_a), .d_b (d_b), .adr_a (adr_a), .adr_b (adr_b),
        .we_a (we_a), .we_b (we_b), .be_a (be_a), .be_b (be_b),
        .q_a (qa0), .q_b (qb0)
    );

    versatile_fifo_dpram_sc_be #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .RDW_MODE (1), .OUT_REG (1), .INIT_VALUE (INIT)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .clr (clr), .init_busy (busy1),
        .d_a (d_a), .d_b (d_b), .adr_a (adr_a), .adr_b (adr_b),
        .we_a (we_a), .we_b (we_b), .be_a (be_a), .be_b (be_b),
        .q_a (qa1), .q_b (qb1)
    );

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] mem_m [DEPTH];
    int          busy_left = DEPTH;
    bit          busy_exp  = 1'b1;
    int          cyc       = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: word-level memory, busy countdown, expected reads per edge
    task automatic model_edge();
        logic [31:0] oa, ob, ea_n, eb_n, ea_o, eb_o;
        if (!rst_n) begin
            busy_left = DEPTH;
            busy_exp  = 1'b1;
            sb0.delete();
            sb1.delete();
            return;
        end
        if (busy_left > 0) begin
            ea_n = 32'h0; eb_n = 32'h0; ea_o = 32'h0; eb_o = 32'h0;
        end else begin
            oa   = mem_m[adr_a];
            ob   = mem_m[adr_b];
            ea_o = oa;
            eb_o = ob;
            ea_n = we_a ? lanes(oa, d_a, be_a) : oa;
            eb_n = we_b ? lanes(ob, d_b, be_b) : ob;
            if (we_b) mem_m[adr_b] = lanes(mem_m[adr_b], d_b, be_b);
            if (we_a) mem_m[adr_a] = lanes(mem_m[adr_a], d_a, be_a);
        end
        sb0.push_back('{due: cyc,     a: ea_n, b: eb_n});
        sb1.push_back('{due: cyc + 1, a: ea_o, b: eb_o});
        if (clr) begin
            busy_left = DEPTH;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
            end
        end
        busy_exp = (busy_left > 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_edge();
        end
    end

    // Monitor: compare outputs on the falling edge, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset busy0", {31'b0, busy0}, 32'h1);
                check("reset busy1", {31'b0, busy1}, 32'h1);
                check("reset q_a0", qa0, 32'h0);
                check("reset q_b0", qb0, 32'h0);
                check("reset q_a1", qa1, 32'h0);
                check("reset q_b1", qb1, 32'h0);
            end else begin
                check("init_busy0", {31'b0, busy0}, {31'b0, busy_exp});
                check("init_busy1", {31'b0, busy1}, {31'b0, busy_exp});
                while (sb0.size() > 0 && sb0[0].due == cyc) begin
                    e = sb0.pop_front();
                    check("q_a new/lat1", qa0, e.a);
                    check("q_b new/lat1", qb0, e.b);
                end
                while (sb1.size() > 0 && sb1[0].due == cyc) begin
                    e = sb1.pop_front();
                    check("q_a old/lat2", qa1, e.a);
                    check("q_b old/lat2", qb1, e.b);
                end
            end
        end
    end

    task automatic op(input logic wa, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] ba,
                      input logic wb, input logic [3:0] ab, input logic [31:0] db, input logic [3:0] bb);
        @(negedge clk);
        clr  = 1'b0;
        we_a = wa; adr_a = aa; d_a = da; be_a = ba;
        we_b = wb; adr_b = ab; d_b = db; be_b = bb;
    endtask

    task automatic rd(input logic [3:0] aa, input logic [3:0] ab);
        op(1'b0, aa, 32'h0, 4'h0, 1'b0, ab, 32'h0, 4'h0);
    endtask

    task automatic rand_op(input logic force_wa);
        op(force_wa | 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), $urandom(),
           4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
           $urandom(), 4'($urandom_range(15, 0)));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        clr  = 1'b1;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(4'(i), 4'(DEPTH - 1 - i));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        we_a = 1'b0; we_b = 1'b0; adr_a = 4'h0; adr_b = 4'h0;
        d_a = 32'h0; d_b = 32'h0; be_a = 4'h0; be_b = 4'h0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Power-up sweep, reads while busy, then full readback
        repeat (DEPTH) rd(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
        read_all();

        // Byte enables
        op(1'b1, 4'd3, 32'h11223344, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0);
        op(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0101, 1'b0, 4'd0, 32'h0, 4'h0);
        rd(4'd3, 4'd3);

        // Read-during-write, same port and cross port
        op(1'b1, 4'd7, 32'h0, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0);
        op(1'b1, 4'd7, 32'hDEADBEEF, 4'hF, 1'b0, 4'd7, 32'h0, 4'h0);
        rd(4'd7, 4'd7);

        // Same-address collision
        op(1'b1, 4'd2, 32'h0, 4'hF, 1'b0, 4'd0, 32'h0, 4'h0);
        op(1'b1, 4'd2, 32'h000000AA, 4'b0001, 1'b1, 4'd2, 32'hBBBBBBBB, 4'b0011);
        rd(4'd2, 4'd2);

        // Random traffic
        repeat (150) rand_op(1'b0);
        read_all();

        // clr in READY, writes during sweep are dropped
        pulse_clr();
        repeat (DEPTH) rand_op(1'b1);
        read_all();

        // Reset in the middle of a sweep
        pulse_clr();
        repeat (9) rand_op(1'b1);
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (DEPTH) rand_op(1'b1);
        read_all();

        repeat (100) rand_op(1'b0);
        repeat (4) rd(4'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
